// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with the writeback result select and the sub-word load
// formatter. It also keeps a count of retired instructions.
module writeback_stage #(
    parameter int D_WIDTH    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_w,
    input  logic                  flush_w,
    input  logic                  valid_m,
    input  logic                  reg_write_m,
    input  logic [1:0]            result_src_m,
    input  logic [2:0]            funct3_m,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [D_WIDTH-1:0]    alu_result_m,
    input  logic [D_WIDTH-1:0]    read_data_m,
    input  logic [D_WIDTH-1:0]    pc_plus4_m,
    input  logic [D_WIDTH-1:0]    imm_ext_m,
    output logic                  valid_w,
    output logic                  reg_write_w,
    output logic [REG_ADDR_W-1:0] rd_w,
    output logic [D_WIDTH-1:0]    result_w,
    output logic [CNT_WIDTH-1:0]  instret
);

    localparam int OFF_W = (D_WIDTH == 64) ? 3 : 2;

    logic [OFF_W-1:0]   off;
    logic [OFF_W-1:0]   off_h;
    logic [OFF_W-1:0]   off_w;
    logic [7:0]         byte_v;
    logic [15:0]        half_v;
    logic [31:0]        word_v;
    logic [D_WIDTH-1:0] load_val;
    logic [D_WIDTH-1:0] result_sel;

    always_comb begin
        off   = alu_result_m[OFF_W-1:0];
        off_h = {off[OFF_W-1:1], 1'b0};
        // On a 32-bit datapath the word lane is always the whole read word.
        off_w = (D_WIDTH == 64) ? {off[OFF_W-1], {(OFF_W-1){1'b0}}} : '0;

        byte_v = 8'(read_data_m >> {off, 3'b000});
        half_v = 16'(read_data_m >> {off_h, 3'b000});
        word_v = 32'(read_data_m >> {off_w, 3'b000});

        case (funct3_m)
            3'b000:  load_val = D_WIDTH'($signed(byte_v));
            3'b001:  load_val = D_WIDTH'($signed(half_v));
            3'b100:  load_val = D_WIDTH'(byte_v);
            3'b101:  load_val = D_WIDTH'(half_v);
            3'b010:  load_val = D_WIDTH'($signed(word_v));
            3'b110:  load_val = D_WIDTH'(word_v);
            default: load_val = read_data_m;
        endcase

        case (result_src_m)
            2'b00:   result_sel = alu_result_m;
            2'b01:   result_sel = load_val;
            2'b10:   result_sel = pc_plus4_m;
            default: result_sel = imm_ext_m;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_w     <= 1'b0;
            reg_write_w <= 1'b0;
            rd_w        <= '0;
            result_w    <= '0;
            instret     <= '0;
        end else if (flush_w) begin
            valid_w     <= 1'b0;
            reg_write_w <= 1'b0;
        end else if (!stall_w) begin
            valid_w     <= valid_m;
            reg_write_w <= valid_m & reg_write_m & (rd_m != '0);
            rd_w        <= rd_m;
            result_w    <= result_sel;
            if (valid_m)
                instret <= instret + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed plan items plus random traffic on 32-bit, 4-bit-counter
// and 64-bit instances, all checked against a behavioural model kept in this file.
module tb_writeback_stage;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        valid;
        logic        rw;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic [63:0] pc;
        logic [63:0] imm;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic [4:0]  rd;
        logic [63:0] res;
        logic [63:0] cnt;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  i32 = '0;
    in_t  i64 = '0;
    st_t  m32 = '0;
    st_t  m64 = '0;
    int   total = 0;
    int   bad = 0;

    logic        v32, w32, v4, w4, v64, w64;
    logic [4:0]  rd32, rd4, rd64;
    logic [31:0] res32, res4;
    logic [63:0] res64, cnt32, cnt64;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    writeback_stage dut32 (
        .clk(clk), .rst(rst), .stall_w(i32.stall), .flush_w(i32.flush), .valid_m(i32.valid),
        .reg_write_m(i32.rw), .result_src_m(i32.src), .funct3_m(i32.f3), .rd_m(i32.rd),
        .alu_result_m(i32.alu[31:0]), .read_data_m(i32.rdata[31:0]), .pc_plus4_m(i32.pc[31:0]),
        .imm_ext_m(i32.imm[31:0]), .valid_w(v32), .reg_write_w(w32), .rd_w(rd32),
        .result_w(res32), .instret(cnt32)
    );

    writeback_stage #(.CNT_WIDTH(4)) dut_c4 (
        .clk(clk), .rst(rst), .stall_w(i32.stall), .flush_w(i32.flush), .valid_m(i32.valid),
        .reg_write_m(i32.rw), .result_src_m(i32.src), .funct3_m(i32.f3), .rd_m(i32.rd),
        .alu_result_m(i32.alu[31:0]), .read_data_m(i32.rdata[31:0]), .pc_plus4_m(i32.pc[31:0]),
        .imm_ext_m(i32.imm[31:0]), .valid_w(v4), .reg_write_w(w4), .rd_w(rd4),
        .result_w(res4), .instret(cnt4)
    );

    writeback_stage #(.D_WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .stall_w(i64.stall), .flush_w(i64.flush), .valid_m(i64.valid),
        .reg_write_m(i64.rw), .result_src_m(i64.src), .funct3_m(i64.f3), .rd_m(i64.rd),
        .alu_result_m(i64.alu), .read_data_m(i64.rdata), .pc_plus4_m(i64.pc),
        .imm_ext_m(i64.imm), .valid_w(v64), .reg_write_w(w64), .rd_w(rd64),
        .result_w(res64), .instret(cnt64)
    );

    function automatic logic [63:0] sext(logic [63:0] x, int bits);
        if (x[bits-1])
            return x | (~64'd0 << bits);
        return x;
    endfunction

    function automatic logic [63:0] load_fmt(logic [2:0] f3, logic [63:0] addr, logic [63:0] d, int w);
        int          nb = w / 8;
        int          off = int'(addr % 64'(nb));
        logic [63:0] mask = (w == 64) ? ~64'd0 : 64'hFFFF_FFFF;
        logic [63:0] b = (d >> (8 * off)) & 64'hFF;
        logic [63:0] h = (d >> (8 * (off - off % 2))) & 64'hFFFF;
        logic [63:0] wd = (w == 64) ? ((d >> (8 * (off - off % 4))) & 64'hFFFF_FFFF) : (d & mask);
        logic [63:0] r;
        case (f3)
            3'd0:    r = sext(b, 8);
            3'd1:    r = sext(h, 16);
            3'd4:    r = b;
            3'd5:    r = h;
            3'd2:    r = (w == 64) ? sext(wd, 32) : d;
            3'd6:    r = wd;
            default: r = d;
        endcase
        return r & mask;
    endfunction

    function automatic st_t step(st_t s, in_t i, int w);
        st_t         n = s;
        logic [63:0] mask = (w == 64) ? ~64'd0 : 64'hFFFF_FFFF;
        if (i.flush) begin
            n.valid = 1'b0;
            n.rw    = 1'b0;
        end else if (!i.stall) begin
            n.valid = i.valid;
            n.rw    = i.valid && i.rw && (i.rd != 5'd0);
            n.rd    = i.rd;
            case (i.src)
                2'd0:    n.res = i.alu & mask;
                2'd1:    n.res = load_fmt(i.f3, i.alu, i.rdata & mask, w);
                2'd2:    n.res = i.pc & mask;
                default: n.res = i.imm & mask;
            endcase
            if (i.valid)
                n.cnt = s.cnt + 64'd1;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m32 = '0;
            m64 = '0;
        end else begin
            m32 = step(m32, i32, 32);
            m64 = step(m64, i64, 64);
        end
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("valid32", 64'(v32), 64'(m32.valid));
        chk("rw32", 64'(w32), 64'(m32.rw));
        chk("rd32", 64'(rd32), 64'(m32.rd));
        chk("res32", 64'(res32), m32.res);
        chk("cnt32", cnt32, m32.cnt);
        chk("res_c4", 64'(res4), m32.res);
        chk("cnt_c4", 64'(cnt4), m32.cnt % 64'd16);
        chk("valid64", 64'(v64), 64'(m64.valid));
        chk("rw64", 64'(w64), 64'(m64.rw));
        chk("rd64", 64'(rd64), 64'(m64.rd));
        chk("res64", res64, m64.res);
        chk("cnt64", cnt64, m64.cnt);
    endtask

    task automatic rand_in(output in_t i);
        i.stall = ($urandom_range(4) == 0);
        i.flush = ($urandom_range(9) == 0);
        i.valid = ($urandom_range(3) != 0);
        i.rw    = 1'($urandom);
        i.src   = 2'($urandom);
        i.f3    = 3'($urandom);
        i.rd    = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom);
        i.alu   = {$urandom, $urandom};
        i.rdata = {$urandom, $urandom};
        i.pc    = {$urandom, $urandom};
        i.imm   = {$urandom, $urandom};
    endtask

    task automatic do_load(string tag, logic [2:0] f3, logic [63:0] addr, logic [63:0] exp);
        i32       = '0;
        i32.valid = 1'b1;
        i32.rw    = 1'b1;
        i32.rd    = 5'd3;
        i32.src   = 2'd1;
        i32.f3    = f3;
        i32.alu   = addr;
        i32.rdata = 64'h80F1_7F82;
        tick();
        chk(tag, 64'(res32), exp);
        chk_all();
    endtask

    logic [63:0] saved_cnt;

    initial begin
        #12;
        chk("reset_valid", 64'(v32), 64'd0);
        chk("reset_cnt", cnt32, 64'd0);
        chk_all();
        rst = 1'b0;

        // Retire seven, then reset between edges.
        i32 = '0;
        i32.valid = 1'b1;
        i32.rw = 1'b1;
        i32.rd = 5'd7;
        i32.alu = 64'h55;
        for (int k = 0; k < 7; k++) tick();
        chk("pre_rst_cnt", cnt32, 64'd7);
        chk("pre_rst_valid", 64'(v32), 64'd1);
        #2 rst = 1'b1;
        #1;
        m32 = '0;
        m64 = '0;
        chk("async_rst_cnt", cnt32, 64'd0);
        chk("async_rst_res", 64'(res32), 64'd0);
        chk_all();
        tick();
        chk_all();
        #3 rst = 1'b0;

        do_load("lb_01", 3'd0, 64'h1001, 64'h0000_007F);
        do_load("lb_00", 3'd0, 64'h1000, 64'hFFFF_FF82);
        do_load("lhu_10", 3'd5, 64'h1002, 64'h0000_80F1);
        do_load("lh_11", 3'd1, 64'h1003, 64'hFFFF_80F1);

        i32 = '0;
        i32.valid = 1'b1;
        i32.rw = 1'b1;
        i32.rd = 5'd1;
        i32.src = 2'd2;
        i32.pc = 64'h104;
        tick();
        chk("src_pc4", 64'(res32), 64'h104);
        i32.src = 2'd3;
        i32.imm = 64'h1234_5000;
        tick();
        chk("src_imm", 64'(res32), 64'h1234_5000);
        chk_all();

        // Stall holds everything; flush wins over stall.
        i32 = '0;
        i32.valid = 1'b1;
        i32.rw = 1'b1;
        i32.rd = 5'd5;
        i32.alu = 64'hAA;
        tick();
        saved_cnt = m32.cnt;
        chk("cap_rd5", 64'(rd32), 64'd5);
        for (int k = 0; k < 3; k++) begin
            i32.stall = 1'b1;
            i32.rd = 5'd9;
            i32.alu = 64'($urandom);
            tick();
            chk("stall_rd", 64'(rd32), 64'd5);
            chk("stall_res", 64'(res32), 64'hAA);
            chk("stall_cnt", cnt32, saved_cnt);
            chk_all();
        end
        i32.flush = 1'b1;
        tick();
        chk("flush_valid", 64'(v32), 64'd0);
        chk("flush_rw", 64'(w32), 64'd0);
        chk("flush_rd", 64'(rd32), 64'd5);
        chk("flush_cnt", cnt32, saved_cnt);
        chk_all();

        // x0 write suppressed but still retires; bubble does not retire.
        i32 = '0;
        i32.valid = 1'b1;
        i32.rw = 1'b1;
        i32.rd = 5'd0;
        tick();
        chk("x0_rw", 64'(w32), 64'd0);
        chk("x0_valid", 64'(v32), 64'd1);
        chk("x0_cnt", cnt32, saved_cnt + 64'd1);
        i32.valid = 1'b0;
        i32.rd = 5'd4;
        tick();
        chk("bubble_cnt", cnt32, saved_cnt + 64'd1);
        chk("bubble_rw", 64'(w32), 64'd0);
        chk_all();

        // 64-bit LWU from the upper word.
        i64 = '0;
        i64.valid = 1'b1;
        i64.rw = 1'b1;
        i64.rd = 5'd2;
        i64.src = 2'd1;
        i64.f3 = 3'd6;
        i64.alu = 64'h4;
        i64.rdata = 64'hFFFF_FFFF_0000_0001;
        tick();
        chk("lwu64_off4", res64, 64'h0000_0000_FFFF_FFFF);
        chk_all();

        for (int k = 0; k < 400; k++) begin
            rand_in(i32);
            rand_in(i64);
            tick();
            chk_all();
        end

        // Counter wrap on the 4-bit instance.
        i32 = '0;
        i64 = '0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        m32 = '0;
        m64 = '0;
        i32.valid = 1'b1;
        for (int k = 0; k < 17; k++) tick();
        chk("wrap_c4", 64'(cnt4), 64'd1);
        chk("wrap_cnt32", cnt32, 64'd17);
        chk_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
